// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select codes, fetch state encoding and reset PC.
package cpu_pkg;

    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_JR     = 2'b11;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/npc.sv
// Combinational next-PC selector: sequential, taken branch, jump and register jump.
module npc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr_idx,
    input  logic [31:0] rs_data,
    input  logic [1:0]  npc_op,
    output logic [31:0] next_pc,
    output logic        misalign
);
    logic [31:0] seq_pc;
    logic [31:0] br_off;

    assign seq_pc = pc + 32'd4;
    assign br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};

    always_comb begin
        next_pc  = seq_pc;
        misalign = 1'b0;
        case (npc_op)
            NPC_PLUS4:  next_pc = seq_pc;
            NPC_BRANCH: next_pc = seq_pc + br_off;
            NPC_JUMP:   next_pc = {seq_pc[31:28], instr_idx, 2'b00};
            NPC_JR: begin
                // Low bits are dropped so the PC stays aligned; the error is reported instead.
                next_pc  = {rs_data[31:2], 2'b00};
                misalign = |rs_data[1:0];
            end
            default:    next_pc = seq_pc;
        endcase
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches over req/ack, holds the instruction until executed.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rstn,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic [31:0]  pc,
    output logic [31:0]  pc_plus4,
    input  logic         exec_done,
    input  logic [1:0]   npc_op,
    input  logic [31:0]  rs_data,
    output logic         align_err
);
    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, instr_reg;
    logic         align_err_reg;
    logic         fetch_accept, exec_accept;
    logic [31:0]  next_pc;
    logic         misalign;

    npc u_npc (
        .pc        (pc_reg),
        .instr_idx (instr_reg[25:0]),
        .rs_data   (rs_data),
        .npc_op    (npc_op),
        .next_pc   (next_pc),
        .misalign  (misalign)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request and valid come only from the state register, never from inputs.
    always_comb begin
        state_next   = state_reg;
        fetch_accept = 1'b0;
        exec_accept  = 1'b0;
        imem.imem_req = 1'b0;
        instr_valid  = 1'b0;
        case (state_reg)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    fetch_accept = 1'b1;
                    state_next   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (exec_done) begin
                    exec_accept = 1'b1;
                    state_next  = ST_FETCH;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_reg        <= RESET_PC;
            instr_reg     <= 32'd0;
            align_err_reg <= 1'b0;
        end else begin
            if (fetch_accept) begin
                instr_reg <= imem.imem_rdata;
            end
            if (exec_accept) begin
                pc_reg <= next_pc;
                if (misalign) begin
                    align_err_reg <= 1'b1;
                end
            end
        end
    end

    assign imem.imem_addr = pc_reg;
    assign pc             = pc_reg;
    assign pc_plus4       = pc_reg + 32'd4;
    assign instr          = instr_reg;
    assign align_err      = align_err_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model checked every cycle.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] instr, pc, pc_plus4, rs_data;
    logic        instr_valid, exec_done, align_err;
    logic [1:0]  npc_op;
    int          checks = 0;
    int          errors = 0;
    bit          cmp_en = 1'b0;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .imem        (imem),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .exec_done   (exec_done),
        .npc_op      (npc_op),
        .rs_data     (rs_data),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one instruction in flight, PC moves only when execution completes.
    logic [31:0] m_pc = 32'h0000_3000;
    logic [31:0] m_instr = 32'd0;
    bit          m_live = 1'b0;
    bit          m_hold = 1'b0;
    bit          m_err = 1'b0;

    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ir,
                                               input logic [1:0] op, input logic [31:0] rs);
        int off;
        off = $signed(ir[15:0]);
        case (op)
            2'b00:   return cur + 32'd4;
            2'b01:   return cur + 32'd4 + 32'(off * 4);
            2'b10:   return ((cur + 32'd4) & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 32'd4);
            default: return rs & ~32'd3;
        endcase
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_pc <= 32'h0000_3000; m_instr <= 32'd0;
            m_live <= 1'b0; m_hold <= 1'b0; m_err <= 1'b0;
        end else if (!m_live) begin
            m_live <= 1'b1;
        end else if (!m_hold) begin
            if (imem.imem_ack) begin
                m_instr <= imem.imem_rdata;
                m_hold  <= 1'b1;
                $display("fetch  pc=%h instr=%h", m_pc, imem.imem_rdata);
            end
        end else if (exec_done) begin
            m_pc   <= model_next(m_pc, m_instr, npc_op, rs_data);
            m_hold <= 1'b0;
            if (npc_op == 2'b11 && rs_data[1:0] != 2'b00) m_err <= 1'b1;
            $display("exec   pc=%h op=%0d next=%h", m_pc, npc_op,
                     model_next(m_pc, m_instr, npc_op, rs_data));
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_req",   32'(imem.imem_req), 32'(m_live && !m_hold));
            chk("cmp_valid", 32'(instr_valid),   32'(m_hold));
            chk("cmp_addr",  imem.imem_addr,     m_pc);
            chk("cmp_pc",    pc,                 m_pc);
            chk("cmp_pc4",   pc_plus4,           m_pc + 32'd4);
            chk("cmp_instr", instr,              m_instr);
            chk("cmp_err",   32'(align_err),     32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem.imem_req && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("req_timeout", 32'(imem.imem_req), 32'd1);
    endtask

    task automatic fetch(input logic [31:0] word, input int waits);
        wait_req();
        repeat (waits) begin
            imem.imem_rdata = $urandom;
            step();
        end
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = word;
        step();
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = $urandom;
    endtask

    task automatic execute(input logic [1:0] op, input logic [31:0] rs);
        exec_done = 1'b1;
        npc_op    = op;
        rs_data   = rs;
        step();
        exec_done = 1'b0;
        npc_op    = 2'($urandom);
        rs_data   = $urandom;
    endtask

    task automatic reset_dut();
        rstn = 1'b0;
        #1;
        chk("rst_pc",    pc,                     32'h0000_3000);
        chk("rst_instr", instr,                  32'd0);
        chk("rst_valid", 32'(instr_valid),       32'd0);
        chk("rst_req",   32'(imem.imem_req),     32'd0);
        chk("rst_err",   32'(align_err),         32'd0);
        step();
        rstn = 1'b1;
        chk("idle_req",  32'(imem.imem_req),     32'd0);
        step();
        chk("first_req", 32'(imem.imem_req),     32'd1);
    endtask

    initial begin
        imem.imem_ack = 1'b0; imem.imem_rdata = 32'd0;
        exec_done = 1'b0; npc_op = 2'b00; rs_data = 32'd0;
        repeat (3) step();
        cmp_en = 1'b1;

        // Back-to-back instructions with zero-wait acks.
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            wait_req();
            chk("seq_addr", imem.imem_addr, 32'h0000_3000 + 32'(i * 4));
            fetch(32'h2008_0005, 0);
            chk("seq_valid_hi", 32'(instr_valid), 32'd1);
            execute(2'b00, 32'd0);
            chk("seq_valid_lo", 32'(instr_valid), 32'd0);
            chk("seq_req_back", 32'(imem.imem_req), 32'd1);
        end
        chk("seq_pc", pc, 32'h0000_300C);

        // Ack withheld three cycles; a stray exec_done during FETCH must do nothing.
        reset_dut();
        exec_done = 1'b1; npc_op = 2'b10;
        for (int i = 0; i < 3; i++) begin
            chk("wait_req",   32'(imem.imem_req), 32'd1);
            chk("wait_addr",  imem.imem_addr,     32'h0000_3000);
            chk("wait_valid", 32'(instr_valid),   32'd0);
            imem.imem_rdata = $urandom;
            step();
        end
        exec_done = 1'b0;
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'h2008_0005;
        chk("wait_req4",  32'(imem.imem_req), 32'd1);
        chk("wait_addr4", imem.imem_addr,     32'h0000_3000);
        step();
        imem.imem_ack = 1'b0;
        chk("wait_valid_hi", 32'(instr_valid), 32'd1);
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
        step();
        imem.imem_ack = 1'b0;
        chk("issue_ack_ignored", instr, 32'h2008_0005);
        execute(2'b00, 32'd0);
        for (int i = 0; i < 3; i++) begin
            fetch(32'h2008_0005, 0);
            execute(2'b00, 32'd0);
        end
        chk("br_start_pc", pc, 32'h0000_3010);
        fetch(32'h1000_FFFE, 0);
        execute(2'b01, 32'd0);
        chk("br_back_pc", pc, 32'h0000_300C);
        fetch(32'h2008_0005, 0);
        execute(2'b00, 32'd0);
        fetch(32'h1000_0003, 1);
        execute(2'b01, 32'd0);
        chk("br_fwd_pc", pc, 32'h0000_3020);

        // Jump, register jumps with sticky misalignment, and PC wrap.
        reset_dut();
        fetch(32'h0800_0C40, 0);
        execute(2'b10, 32'd0);
        chk("jump_pc", pc, 32'h0000_3100);
        fetch(32'h0000_0008, 0);
        execute(2'b11, 32'h0000_3202);
        chk("jr_pc",  pc,              32'h0000_3200);
        chk("jr_err", 32'(align_err),  32'd1);
        fetch(32'h0000_0008, 2);
        execute(2'b11, 32'h0000_3300);
        chk("jr2_pc",     pc,             32'h0000_3300);
        chk("jr2_err",    32'(align_err), 32'd1);
        fetch(32'h0000_0008, 0);
        execute(2'b11, 32'hFFFF_FFFC);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        fetch(32'h2008_0005, 0);
        execute(2'b00, 32'd0);
        chk("wrap_pc",  pc,       32'd0);
        chk("wrap_pc4", pc_plus4, 32'd4);

        // Reset while waiting in FETCH, then a late ack that must be discarded.
        reset_dut();
        fetch(32'h2008_0005, 0);
        execute(2'b00, 32'd0);
        imem.imem_rdata = 32'h1234_5678;
        step();
        rstn = 1'b0;
        #1;
        chk("midrst_pc",    pc,                 32'h0000_3000);
        chk("midrst_instr", instr,              32'd0);
        chk("midrst_req",   32'(imem.imem_req), 32'd0);
        imem.imem_ack = 1'b1; imem.imem_rdata = 32'hCAFE_F00D;
        step();
        rstn = 1'b1;
        step();
        imem.imem_ack = 1'b0;
        chk("late_valid", 32'(instr_valid),   32'd0);
        chk("late_instr", instr,              32'd0);
        chk("late_req",   32'(imem.imem_req), 32'd1);
        chk("late_addr",  imem.imem_addr,     32'h0000_3000);
        fetch(32'h2008_0005, 0);
        chk("restart_instr", instr, 32'h2008_0005);
        execute(2'b00, 32'd0);
        chk("restart_pc", pc, 32'h0000_3004);
        step();

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
